// File: rtl/dma_sample_streamer_pkg.sv
// Shared constants and helpers for the DMA sample streamer: DMA word width, underrun counter
// width and lane arithmetic.
package dma_sample_streamer_pkg;

    localparam int unsigned DMA_W          = 64;
    localparam int unsigned UNDERRUN_CNT_W = 16;

    typedef logic [DMA_W-1:0] dma_word_t;

    function automatic bit sample_w_legal(input int unsigned sample_w);
        return (sample_w == 8) || (sample_w == 16) || (sample_w == 32);
    endfunction

    function automatic int unsigned lane_count(input int unsigned sample_w);
        return DMA_W / sample_w;
    endfunction

endpackage

// File: rtl/dma_sample_streamer_if.sv
// Request/return bus between the streamer (master) and the simple DMA read controller (slave).
interface dma_sample_streamer_if;
    import dma_sample_streamer_pkg::*;

    logic      dma_request;
    dma_word_t dma_data;
    logic      dma_data_ready;

    modport master (
        output dma_request,
        input  dma_data,
        input  dma_data_ready
    );

    modport slave (
        input  dma_request,
        output dma_data,
        output dma_data_ready
    );

endinterface

// File: rtl/sample_rate_divider.sv
// Programmable tick generator: one tick every rate_div+1 enabled cycles, reloadable on demand.
module sample_rate_divider #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             i_enable,
    input  logic             i_reload,
    input  logic [DIV_W-1:0] i_rate_div,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_count;
    logic             w_zero;

    assign w_zero = (r_count == '0);
    assign o_tick = i_enable & ~i_reload & w_zero;

    // Held at rate_div while idle so the first tick lands rate_div+1 cycles after enable.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_count <= '0;
        end else if (!i_enable || i_reload || w_zero) begin
            r_count <= i_rate_div;
        end else begin
            r_count <= r_count - DIV_W'(1);
        end
    end

endmodule

// File: rtl/dma_sample_streamer.sv
// Pulls 64-bit words from the DMA controller into a small buffer and plays them out one
// SAMPLE_W lane per rate tick, substituting zero samples and counting underruns when empty.
module dma_sample_streamer
    import dma_sample_streamer_pkg::*;
#(
    parameter int unsigned BUF_DEPTH = 2,
    parameter int unsigned SAMPLE_W  = 16,
    parameter int unsigned DIV_W     = 16
) (
    input  logic                        clk,
    input  logic                        rst_b,
    input  logic                        i_enable,
    input  logic                        i_flush,
    input  logic [DIV_W-1:0]            i_rate_div,
    dma_sample_streamer_if.master       dma,
    output logic [SAMPLE_W-1:0]         o_sample,
    output logic                        o_sample_valid,
    output logic                        o_underrun,
    output logic [UNDERRUN_CNT_W-1:0]   o_underrun_count,
    output logic [$clog2(BUF_DEPTH):0]  o_buf_level
);

    localparam int unsigned LANES  = lane_count(SAMPLE_W);
    localparam int unsigned LANE_W = $clog2(LANES);
    localparam int unsigned PTR_W  = $clog2(BUF_DEPTH);
    localparam int unsigned LVL_W  = PTR_W + 1;

    dma_word_t                 r_buf [BUF_DEPTH];
    logic [PTR_W-1:0]          r_wr_ptr;
    logic [PTR_W-1:0]          r_rd_ptr;
    logic [LVL_W-1:0]          r_level;
    logic                      r_pending;
    logic [LANE_W-1:0]         r_lane;
    logic [SAMPLE_W-1:0]       r_sample;
    logic                      r_sample_valid;
    logic                      r_underrun;
    logic [UNDERRUN_CNT_W-1:0] r_underrun_count;

    logic                      w_tick;
    logic                      w_request;
    logic                      w_push;
    logic                      w_has_data;
    logic                      w_last_lane;
    logic                      w_pop;
    dma_word_t                 w_word;
    logic [SAMPLE_W-1:0]       w_lane_data;

    sample_rate_divider #(
        .DIV_W (DIV_W)
    ) u_divider (
        .clk        (clk),
        .rst_b      (rst_b),
        .i_enable   (i_enable),
        .i_reload   (i_flush),
        .i_rate_div (i_rate_div),
        .o_tick     (w_tick)
    );

    // The in-flight word counts against capacity, so an accepted response always fits.
    assign w_request = i_enable & ~i_flush & ~r_pending &
                       (({1'b0, r_level} + {{LVL_W{1'b0}}, r_pending}) <
                        (LVL_W + 1)'(BUF_DEPTH));
    assign dma.dma_request = w_request;

    assign w_push      = dma.dma_data_ready & r_pending & ~i_flush;
    assign w_has_data  = (r_level != '0);
    assign w_last_lane = (r_lane == LANE_W'(LANES - 1));
    assign w_pop       = w_tick & w_has_data & w_last_lane;
    assign w_word      = r_buf[r_rd_ptr];

    always_comb begin
        w_lane_data = '0;
        for (int l = 0; l < LANES; l++) begin
            if (r_lane == LANE_W'(l)) begin
                w_lane_data = w_word[l*SAMPLE_W +: SAMPLE_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_buf[i] <= '0;
            end
        end else if (w_push) begin
            r_buf[r_wr_ptr] <= dma.dma_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_lane   <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_lane   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + LVL_W'(1);
            end else if (w_pop && !w_push) begin
                r_level <= r_level - LVL_W'(1);
            end
            if (w_tick && w_has_data) begin
                r_lane <= w_last_lane ? '0 : r_lane + LANE_W'(1);
            end
        end
    end

    // The controller answers exactly one cycle after a request or never, so pending lasts one cycle.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_pending <= 1'b0;
        end else begin
            r_pending <= w_request;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_sample         <= '0;
            r_sample_valid   <= 1'b0;
            r_underrun       <= 1'b0;
            r_underrun_count <= '0;
        end else begin
            r_sample_valid <= w_tick;
            r_underrun     <= w_tick & ~w_has_data;
            if (w_tick) begin
                r_sample <= w_has_data ? w_lane_data : '0;
            end
            if (w_tick && !w_has_data && (r_underrun_count != '1)) begin
                r_underrun_count <= r_underrun_count + UNDERRUN_CNT_W'(1);
            end
        end
    end

    assign o_sample         = r_sample;
    assign o_sample_valid   = r_sample_valid;
    assign o_underrun       = r_underrun;
    assign o_underrun_count = r_underrun_count;
    assign o_buf_level      = r_level;

endmodule

// File: tb/tb_dma_sample_streamer.sv
// Directed bench for dma_sample_streamer: a one-cycle DMA responder model, a scoreboard queue of
// expected samples drained by a monitor, and point checks on request/level/underrun behaviour.
module tb_dma_sample_streamer;
    import dma_sample_streamer_pkg::*;

    localparam int unsigned BUF_DEPTH = 2;
    localparam int unsigned SAMPLE_W  = 16;
    localparam int unsigned DIV_W     = 16;

    typedef struct packed {
        logic        u;
        logic [15:0] s;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        enable;
    logic        flush;
    logic [15:0] rate_div;
    logic [15:0] sample;
    logic        sample_valid;
    logic        underrun;
    logic [15:0] ucount;
    logic [1:0]  level;

    logic        resp_on;
    logic        force_ready;
    logic [63:0] resp_word;
    int          req_cnt = 0;

    int          n_tests = 0;
    int          n_fail  = 0;
    bit          sb_en   = 1'b1;
    exp_t        exp_q[$];

    dma_sample_streamer_if dma_if ();

    dma_sample_streamer #(
        .BUF_DEPTH (BUF_DEPTH),
        .SAMPLE_W  (SAMPLE_W),
        .DIV_W     (DIV_W)
    ) dut (
        .clk              (clk),
        .rst_b            (rst_b),
        .i_enable         (enable),
        .i_flush          (flush),
        .i_rate_div       (rate_div),
        .dma              (dma_if),
        .o_sample         (sample),
        .o_sample_valid   (sample_valid),
        .o_underrun       (underrun),
        .o_underrun_count (ucount),
        .o_buf_level      (level)
    );

    always #5 clk = ~clk;

    // Controller model: answers one cycle after each request; force_ready injects stray responses.
    always @(posedge clk) begin
        dma_if.dma_data_ready <= (resp_on & dma_if.dma_request) | force_ready;
        dma_if.dma_data       <= resp_word;
        if (dma_if.dma_request) req_cnt <= req_cnt + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_b && sb_en && sample_valid) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_sample: got sample %0h underrun %0b, expected none",
                             sample, underrun);
                end else begin
                    e = exp_q.pop_front();
                    chk("sample", {47'd0, underrun, sample}, {47'd0, e.u, e.s});
                end
            end
        end
    endtask

    task automatic quiesce();
        enable = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic drain(input string name, input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int first;
        int maxl;
        int k;
        int r0;

        rst_b       = 1'b0;
        enable      = 1'b0;
        flush       = 1'b0;
        rate_div    = 16'd3;
        resp_on     = 1'b0;
        force_ready = 1'b0;
        resp_word   = 64'd0;
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_sample", 64'(sample), 64'd0);
        chk("rst_valid", 64'(sample_valid), 64'd0);
        chk("rst_underrun", 64'(underrun), 64'd0);
        chk("rst_ucount", 64'(ucount), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_request", 64'(dma_if.dma_request), 64'd0);
        rst_b = 1'b1;
        @(negedge clk);

        // 1: steady state, rate_div=3
        resp_on   = 1'b1;
        resp_word = 64'h0004_0003_0002_0001;
        for (int r = 0; r < 2; r++) begin
            for (int i = 1; i <= 4; i++) exp_q.push_back('{u: 1'b0, s: 16'(i)});
        end
        enable = 1'b1;
        first  = -1;
        maxl   = 0;
        k      = 0;
        while (exp_q.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
            if (sample_valid && first < 0) first = k;
            if (int'(level) > maxl) maxl = int'(level);
        end
        enable = 1'b0;
        chk("t1_first_valid", 64'(first), 64'd4);
        chk("t1_max_level", 64'(maxl), 64'd2);
        chk("t1_drained", 64'(exp_q.size()), 64'd0);
        chk("t1_ucount", 64'(ucount), 64'd0);
        resp_on  = 1'b0;
        rate_div = 16'd0;
        quiesce();

        // 2: underrun every cycle, no DMA responses
        for (int i = 0; i < 10; i++) exp_q.push_back('{u: 1'b1, s: 16'd0});
        r0     = req_cnt;
        enable = 1'b1;
        repeat (10) @(negedge clk);
        enable = 1'b0;
        chk("t2_req_pulses", 64'(req_cnt - r0), 64'd5);
        repeat (3) @(negedge clk);
        chk("t2_ucount", 64'(ucount), 64'd10);
        drain("t2_drain", 5);

        // 3: saturation
        sb_en  = 1'b0;
        enable = 1'b1;
        repeat (70000) @(negedge clk);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        chk("t3_ucount_sat", 64'(ucount), 64'hFFFF);
        sb_en    = 1'b1;
        rate_div = 16'd1;
        quiesce();

        // 4: flush while a word is in flight
        resp_on   = 1'b1;
        resp_word = 64'hDDDD_CCCC_BBBB_AAAA;
        exp_q.push_back('{u: 1'b1, s: 16'h0000});
        exp_q.push_back('{u: 1'b0, s: 16'hAAAA});
        exp_q.push_back('{u: 1'b0, s: 16'hBBBB});
        exp_q.push_back('{u: 1'b0, s: 16'hCCCC});
        exp_q.push_back('{u: 1'b0, s: 16'hDDDD});
        enable = 1'b1;
        #1;
        chk("t4_req_t", 64'(dma_if.dma_request), 64'd1);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("t4_level_t2", 64'(level), 64'd0);
        chk("t4_req_t2", 64'(dma_if.dma_request), 64'd1);
        chk("t4_ucount_kept", 64'(ucount), 64'hFFFF);
        repeat (10) @(negedge clk);
        enable = 1'b0;
        drain("t4_drain", 10);
        rate_div  = 16'hFFFF;
        resp_word = 64'h4444_3333_2222_1111;
        quiesce();

        // 5: full buffer with a stalled sink
        r0     = req_cnt;
        enable = 1'b1;
        repeat (20) @(negedge clk);
        chk("t5_level_full", 64'(level), 64'd2);
        chk("t5_req_count", 64'(req_cnt - r0), 64'd2);
        chk("t5_req_low", 64'(dma_if.dma_request), 64'd0);
        enable   = 1'b0;
        rate_div = 16'd3;
        repeat (2) @(negedge clk);
        chk("t5_level_retained", 64'(level), 64'd2);
        for (int i = 1; i <= 4; i++) exp_q.push_back('{u: 1'b0, s: 16'(i * 16'h1111)});
        r0     = req_cnt;
        enable = 1'b1;
        repeat (15) @(negedge clk);
        chk("t5_no_req_drain", 64'(req_cnt - r0), 64'd0);
        chk("t5_req_low_d15", 64'(dma_if.dma_request), 64'd0);
        chk("t5_level_d15", 64'(level), 64'd2);
        @(negedge clk);
        chk("t5_req_after_pop", 64'(dma_if.dma_request), 64'd1);
        chk("t5_level_after_pop", 64'(level), 64'd1);
        enable = 1'b0;
        drain("t5_drain", 10);
        rate_div = 16'd50;
        quiesce();

        // 6: reset while a response is pending, plus a stray late response
        enable = 1'b1;
        @(negedge clk);
        rst_b       = 1'b0;
        enable      = 1'b0;
        force_ready = 1'b1;
        @(negedge clk);
        rst_b       = 1'b1;
        force_ready = 1'b0;
        chk("t6_request", 64'(dma_if.dma_request), 64'd0);
        chk("t6_sample", 64'(sample), 64'd0);
        chk("t6_valid", 64'(sample_valid), 64'd0);
        chk("t6_underrun", 64'(underrun), 64'd0);
        chk("t6_ucount", 64'(ucount), 64'd0);
        chk("t6_level", 64'(level), 64'd0);
        repeat (2) @(negedge clk);
        chk("t6_late_ignored", 64'(level), 64'd0);

        drain("final_drain", 5);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
